// File: rtl/if_pkg.sv
// Shared defaults, address helpers and the fetch-entry layout for the fetch queue.
package if_pkg;
  localparam int DEF_FETCH_WIDTH = 2;
  localparam int DEF_INSTR_W     = 32;
  localparam int DEF_ADDR_W      = 32;

  function automatic int block_bytes(input int fetch_width, input int instr_w);
    return fetch_width * instr_w / 8;
  endfunction

  function automatic int align_shift(input int fetch_width, input int instr_w);
    return $clog2(block_bytes(fetch_width, instr_w));
  endfunction

  function automatic logic [63:0] align_addr(input logic [63:0] addr, input int sh);
    return (addr >> sh) << sh;
  endfunction

  // Entry layout at the default widths; the top rebuilds it at its own widths.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0]                  pc;
    logic [DEF_FETCH_WIDTH*DEF_INSTR_W-1:0] instr;
    logic [DEF_FETCH_WIDTH-1:0]             mask;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and full/empty flags.
module if_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so stale storage never leaks out.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && RESET && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: block fetch, in-flight tracking, redirect squash, decode queue.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int FETCH_WIDTH = DEF_FETCH_WIDTH,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INSTR_W     = DEF_INSTR_W
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [ADDR_W-1:0]              PC_init,
  input  logic                           FREEZE,
  input  logic                           redirect_valid,
  input  logic [ADDR_W-1:0]              redirect_addr,
  output logic                           im_req_valid,
  output logic [ADDR_W-1:0]              im_addr,
  input  logic [FETCH_WIDTH*INSTR_W-1:0] im_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDR_W-1:0]              out_pc,
  output logic [FETCH_WIDTH*INSTR_W-1:0] out_instr,
  output logic [FETCH_WIDTH-1:0]         out_mask,
  output logic [$clog2(DEPTH):0]         out_count
);
  localparam int ALIGN_SH = align_shift(FETCH_WIDTH, INSTR_W);
  localparam int WORD_SH  = $clog2(INSTR_W / 8);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(block_bytes(FETCH_WIDTH, INSTR_W));

  typedef struct packed {
    logic [ADDR_W-1:0]              pc;
    logic [FETCH_WIDTH*INSTR_W-1:0] instr;
    logic [FETCH_WIDTH-1:0]         mask;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    return ADDR_W'(align_addr(64'(a), ALIGN_SH));
  endfunction

  // Lanes below the target's word offset within the block are not valid.
  function automatic logic [FETCH_WIDTH-1:0] lane_mask(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0]      lane;
    logic [FETCH_WIDTH-1:0] m;
    lane = (a >> WORD_SH) & ADDR_W'(FETCH_WIDTH - 1);
    for (int i = 0; i < FETCH_WIDTH; i++) m[i] = (ADDR_W'(i) >= lane);
    return m;
  endfunction

  logic [ADDR_W-1:0]      fetch_pc;
  logic [ADDR_W-1:0]      infl_pc;
  logic [FETCH_WIDTH-1:0] start_mask;
  logic [FETCH_WIDTH-1:0] infl_mask;
  logic [FETCH_WIDTH-1:0] req_mask;
  logic                   inflight;
  logic                   infl_epoch;
  logic                   epoch;
  logic                   room;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  entry_t                 wr_entry;
  entry_t                 rd_entry;

  assign out_valid = !empty && !FREEZE;
  assign pop       = out_valid && out_ready;
  // A redirect flushes the queue, so it always has room for the new request.
  assign room      = redirect_valid ||
                     ((int'(out_count) - int'(pop) + int'(inflight)) < DEPTH);
  assign im_req_valid = RESET && !FREEZE && room;
  assign im_addr      = redirect_valid ? align(redirect_addr) : fetch_pc;
  assign req_mask     = redirect_valid ? lane_mask(redirect_addr) : start_mask;

  assign push     = inflight && (infl_epoch == epoch) && !redirect_valid;
  assign wr_entry = '{pc: infl_pc, instr: im_rdata, mask: infl_mask};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      fetch_pc   <= align(PC_init);
      start_mask <= '1;
      inflight   <= 1'b0;
      infl_epoch <= 1'b0;
      epoch      <= 1'b0;
      infl_pc    <= '0;
      infl_mask  <= '0;
    end else begin
      inflight <= im_req_valid;
      if (redirect_valid) epoch <= ~epoch;
      if (im_req_valid) begin
        fetch_pc   <= im_addr + STRIDE;
        infl_pc    <= im_addr;
        infl_mask  <= req_mask;
        infl_epoch <= redirect_valid ? ~epoch : epoch;
        start_mask <= '1;
      end else if (redirect_valid) begin
        fetch_pc   <= align(redirect_addr);
        start_mask <= lane_mask(redirect_addr);
      end
    end
  end

  if_fetch_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .flush (redirect_valid),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (rd_entry),
    .count (out_count),
    .full  (full),
    .empty (empty)
  );

  assign out_pc    = rd_entry.pc;
  assign out_instr = rd_entry.instr;
  assign out_mask  = rd_entry.mask;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET) !(push && full && !pop));
endmodule
